// File: rtl/cpu_display_scan.sv
// cpu_display_scan: 8-digit multiplexed 7-segment scanner for the CPU status outputs.
// Takes a tear-free 32-bit snapshot of display/cycle_count once per scan frame and shows it
// as hex. It only observes the CPU and never pushes back into it. After the CPU halts, the
// snapshot is frozen and the whole panel blinks.
// Optional build macro: CPU_DISP_LZ_BLANK_EN. When it is defined, leading zero nibbles are dark.
module cpu_display_scan #(
  parameter int DIV_WIDTH    = 17,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] display,
  input  logic [31:0] cycle_count,
  input  logic        halt,
  input  logic        sel_cycle,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

  // Hex nibble to active-low {dp,g,f,e,d,c,b,a}; dp stays dark.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           digit_q, digit_d;
  logic [31:0]          shown_q, shown_d;
  logic                 halt_seen_q, halt_seen_d;
  logic [BCW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                 blank_q, blank_d;
  logic [7:0]           an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic                 frame_tick_q, frame_tick_d;

  logic       tick;
  logic       boundary;
  logic       capture;
  logic [3:0] nibble;
  logic       lz_dark;
  logic       dark;

  // Scan timing, frame capture, halt tracking and the blink phase.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path leaves one unassigned
    // and no latch can be inferred.
    div_d        = div_q + 1'b1;
    digit_d      = digit_q;
    shown_d      = shown_q;
    halt_seen_d  = halt_seen_q | halt;
    blink_cnt_d  = blink_cnt_q;
    blank_d      = blank_q;
    frame_tick_d = 1'b0;

    tick     = (div_q == {DIV_WIDTH{1'b1}});
    boundary = tick && (digit_q == 3'd7);
    // A halt that arrives on the boundary cycle already blocks that boundary's capture.
    capture  = boundary && !halt_seen_q && !halt;

    if (tick) begin
      digit_d = digit_q + 3'd1;
    end

    if (capture) begin
      shown_d      = sel_cycle ? cycle_count : display;
      frame_tick_d = 1'b1;
    end

    // Only boundaries that occur after the halt has been registered advance the blink phase.
    if (boundary && halt_seen_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Next an/seg values for the digit currently being scanned.
  always_comb begin
    nibble = shown_q[{digit_q, 2'b00} +: 4];
`ifdef CPU_DISP_LZ_BLANK_EN
    // Digit i is dark when every nibble from i upward is zero. Digit 0 is never dark from this rule.
    lz_dark = (digit_q != 3'd0) && ((shown_q >> {digit_q, 2'b00}) == 32'd0);
`else
    lz_dark = 1'b0;
`endif
    dark = blank_q | lz_dark;
    if (dark) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = hex_to_seg(nibble);
    end
  end

  // State register. clr clears everything at once, even in the middle of a frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_q        <= '0;
      digit_q      <= '0;
      shown_q      <= '0;
      halt_seen_q  <= 1'b0;
      blink_cnt_q  <= '0;
      blank_q      <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so that every flop samples the
      // pre-edge values, whatever order the statements are written in.
      div_q        <= div_d;
      digit_q      <= digit_d;
      shown_q      <= shown_d;
      halt_seen_q  <= halt_seen_d;
      blink_cnt_q  <= blink_cnt_d;
      blank_q      <= blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_cpu_display_scan.sv
// Testbench for cpu_display_scan, built with DIV_WIDTH=2 and BLINK_FRAMES=2.
// A reference model works out the expected panel from a count of clock edges since reset.
// Add CPU_DISP_LZ_BLANK_EN to the build to test leading-zero blanking.
module tb_cpu_display_scan;

  localparam int DW    = 2;
  localparam int BF    = 2;
  localparam int CPD   = 4;   // clk cycles per digit
  localparam int FRAME = 32;  // clk cycles per frame

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] display;
  logic [31:0] cycle_count;
  logic        halt;
  logic        sel_cycle;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  cpu_display_scan #(.DIV_WIDTH(DW), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .clr        (clr),
    .display    (display),
    .cycle_count(cycle_count),
    .halt       (halt),
    .sel_cycle  (sel_cycle),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state.
  int          k;            // clock edges since reset was released
  logic [31:0] m_shown;
  bit          m_halt_seen;
  int          m_hcount;     // frame boundaries seen after the halt was registered

  logic [7:0] hex_tab [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  function automatic void render(input int d, input logic [31:0] s, input bit blank,
                                 output logic [7:0] a, output logic [7:0] sg);
    bit dark;
    dark = blank;
`ifdef CPU_DISP_LZ_BLANK_EN
    if (d >= 1 && (s >> (4 * d)) == 32'd0) dark = 1'b1;
`endif
    if (dark) begin
      a  = 8'hFF;
      sg = 8'hFF;
    end else begin
      a  = ~(8'd1 << d);
      sg = hex_tab[(s >> (4 * d)) & 32'hF];
    end
  endfunction

  task automatic model_reset();
    k           = 0;
    m_shown     = 32'd0;
    m_halt_seen = 1'b0;
    m_hcount    = 0;
  endtask

  // Advance one clock. The model works out what the DUT must show after this edge,
  // then the DUT outputs are compared on the following falling edge.
  task automatic step();
    logic [7:0] e_an, e_seg;
    logic       e_ft;
    bit         bnd, cap_ok;
    if (clr) begin
      e_an  = 8'hFF;
      e_seg = 8'hFF;
      e_ft  = 1'b0;
    end else begin
      render((k / CPD) % 8, m_shown, ((m_hcount / BF) % 2) == 1, e_an, e_seg);
      bnd    = (k % FRAME) == FRAME - 1;
      cap_ok = bnd && !m_halt_seen && !halt;
      e_ft   = cap_ok;
      if (cap_ok) m_shown = sel_cycle ? cycle_count : display;
      if (bnd && m_halt_seen) m_hcount++;
      if (halt) m_halt_seen = 1'b1;
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    check("an", {24'd0, an}, {24'd0, e_an});
    check("seg", {24'd0, seg}, {24'd0, e_seg});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  // Reset applied between clock edges. The outputs must clear right away, with no edge needed.
  task automatic async_reset();
    #2 clr = 1'b1;
    #1;
    check("async_rst_an", {24'd0, an}, 32'h0000_00FF);
    check("async_rst_seg", {24'd0, seg}, 32'h0000_00FF);
    check("async_rst_ft", {31'd0, frame_tick}, 32'd0);
    model_reset();
    step();
    clr = 1'b0;
  endtask

  logic [7:0] lit_seg [8];
  logic [7:0] lit_an  [8];

  initial begin
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    lit_seg = '{8'h8E, 8'h88, 8'h90, 8'h80, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    lit_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    clr = 1'b1; display = 32'h0123_89AF; cycle_count = 32'd0; halt = 1'b0; sel_cycle = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_an", {24'd0, an}, 32'h0000_00FF);
    check("rst_seg", {24'd0, seg}, 32'h0000_00FF);
    check("rst_ft", {31'd0, frame_tick}, 32'd0);
    clr = 1'b0;

    // First edge after release: digit 0, shown=0.
    step();
    check("first_an", {24'd0, an}, 32'h0000_00FE);
    check("first_seg", {24'd0, seg}, 32'h0000_00C0);
    run_to(FRAME);
    check("first_tick", {31'd0, frame_tick}, 32'd1);

    // Frame after the first capture, checked against hand-written literals.
    // display changes during digit 3; digits 4..7 must still show the old snapshot.
    for (int j = 0; j < FRAME; j++) begin
      if (j == 3 * CPD) display = 32'hFFFF_FFFF;
      step();
      if (j % CPD == 1) begin
        check("lit_seg", {24'd0, seg}, {24'd0, lit_seg[j / CPD]});
        check("lit_an", {24'd0, an}, {24'd0, lit_an[j / CPD]});
      end
    end
    step();
    check("new_val_seg", {24'd0, seg}, 32'h0000_008E);

    // Show cycle_count, which counts up like the CPU's counter, then switch back mid-frame.
    sel_cycle = 1'b1;
    for (int j = 0; j < 3 * FRAME; j++) begin
      cycle_count = cycle_count + 32'd1;
      if (j == FRAME + 10) sel_cycle = 1'b0;
      if (j == FRAME + 20) sel_cycle = 1'b1;
      if (j == 2 * FRAME + 5) sel_cycle = 1'b0;
      step();
    end

    // One-cycle halt pulse in mid-frame: snapshot freezes, then the panel blinks.
    async_reset();
    display = 32'h0000_5A5A;
    run_to(40);
    halt = 1'b1;
    step();
    halt = 1'b0;
    display = 32'h1111_1111;
    run_to(3 * FRAME + 17);
    check("halt_blank3", {24'd0, an}, 32'h0000_00FF);
    run_to(4 * FRAME + 17);
    check("halt_blank4", {24'd0, an}, 32'h0000_00FF);
    run_to(5 * FRAME + 1);
    check("halt_lit5", {24'd0, an}, 32'h0000_00FE);
    check("halt_frozen5", {24'd0, seg}, 32'h0000_0088);
    run_to(7 * FRAME + 9);
    check("halt_blank7", {24'd0, an}, 32'h0000_00FF);

    // Reset restores capture; then a halt arriving exactly on the boundary cycle.
    async_reset();
    display = 32'h0000_00A5;
    run_to(FRAME + FRAME - 1);
    display = 32'h0000_0000;
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_on_bnd_ft", {31'd0, frame_tick}, 32'd0);
    run_to(6 * FRAME);

    // Leading-zero style values, then random traffic with occasional halts and resets.
    async_reset();
    display = 32'd0;
    run_to(2 * FRAME + 8);
    for (int j = 0; j < 4000; j++) begin
      case ($urandom_range(0, 3))
        0: display = $urandom;
        1: display = $urandom >> $urandom_range(0, 31);
        default: ;
      endcase
      cycle_count = ($urandom_range(0, 7) == 0) ? $urandom : cycle_count + 32'd1;
      if ($urandom_range(0, 40) == 0) sel_cycle = ~sel_cycle;
      halt = ($urandom_range(0, 700) == 0);
      if ($urandom_range(0, 900) == 0) begin
        halt = 1'b0;
        async_reset();
      end else begin
        step();
      end
    end
    halt = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
